// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel WIDTH-bit source selector with a registered output stage.
// Selection is either direct (by order_i) or round-robin among requesting channels.
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   mode_i              - 0 = direct select by order_i, 1 = round-robin arbitration
//   order_i             - channel index used in direct mode
//   in_valid_i/in_ready_o/in_data_i - per-channel handshake; channel i at [i*WIDTH +: WIDTH]
//   out_valid_o/out_ready_i/out_data_o/out_src_o - registered output word and its source
//   sel_err_o           - one-cycle pulse after a direct-mode cycle with order_i >= N and a free slot
// Latency: 1 cycle from accept to out_valid_o. Backpressure: in_ready_o is all zero
// while the output register is full and not being drained.
module mux_arb_n #(
  parameter int WIDTH = 32,
  parameter int N     = 5,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode_i,
  input  logic [SEL_W-1:0]   order_i,
  input  logic [N-1:0]       in_valid_i,
  input  logic [N*WIDTH-1:0] in_data_i,
  output logic [N-1:0]       in_ready_o,
  output logic               out_valid_o,
  output logic [WIDTH-1:0]   out_data_o,
  output logic [SEL_W-1:0]   out_src_o,
  input  logic               out_ready_i,
  output logic               sel_err_o
);

  localparam logic [SEL_W:0]   N_EXT   = (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N - 1);

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q,  out_data_d;
  logic [SEL_W-1:0]   out_src_q,   out_src_d;
  logic [SEL_W-1:0]   ptr_q,       ptr_d;
  logic               sel_err_q,   sel_err_d;

  logic               slot_free;
  logic               order_ok;
  logic               dir_hit;
  logic               rr_found;
  logic [SEL_W-1:0]   rr_idx;
  logic               grant_vld;
  logic [SEL_W-1:0]   grant_idx;
  logic               xfer;

  // The slot can be refilled on the same edge that the consumer drains it.
  assign slot_free = !out_valid_q || out_ready_i;
  assign order_ok  = ({1'b0, order_i} < N_EXT);
  assign dir_hit   = order_ok && in_valid_i[order_i];

  // Round-robin scan starting at ptr_q, wrapping modulo N; first requester wins.
  always_comb begin
    logic [SEL_W:0] sum;
    rr_found = 1'b0;
    rr_idx   = '0;
    sum      = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (SEL_W+1)'(k);
      if (sum >= N_EXT) begin
        sum = sum - N_EXT;
      end
      if (!rr_found && in_valid_i[sum[SEL_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = sum[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (mode_i) begin
      grant_vld = rr_found;
      grant_idx = rr_idx;
    end else if (dir_hit) begin
      grant_vld = 1'b1;
      grant_idx = order_i;
    end
  end

  // Granted channel always has in_valid set, so a grant into a free slot is a transfer.
  assign xfer = grant_vld && slot_free;

  always_comb begin
    in_ready_o = '0;
    if (xfer) begin
      in_ready_o[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data_i[grant_idx*WIDTH +: WIDTH];
      out_src_d   = grant_idx;
      if (mode_i) begin
        ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
      end
    end else if (out_ready_i) begin
      // Data and source are kept so the bus does not toggle on an idle drain.
      out_valid_d = 1'b0;
    end
    sel_err_d = !mode_i && !order_ok && slot_free;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_src_o   = out_src_q;
  assign sel_err_o   = sel_err_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Testbench for mux_arb_n: directed vector table, hand-written corner sequences,
// and a randomized run against a behavioural reference model.
module tb_mux_arb_n;

  localparam int N     = 5;
  localparam int WIDTH = 32;
  localparam int SEL_W = $clog2(N);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               mode_i;
  logic [SEL_W-1:0]   order_i;
  logic [N-1:0]       in_valid_i;
  logic [N*WIDTH-1:0] in_data_i;
  logic [N-1:0]       in_ready_o;
  logic               out_valid_o;
  logic [WIDTH-1:0]   out_data_o;
  logic [SEL_W-1:0]   out_src_o;
  logic               out_ready_i;
  logic               sel_err_o;

  int total = 0;
  int bad   = 0;

  mux_arb_n #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .order_i(order_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_src_o(out_src_o),
    .out_ready_i(out_ready_i), .sel_err_o(sel_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             mode;
    logic [SEL_W-1:0] order;
    logic [N-1:0]     vld;
    logic [N-1:0]     exp_rdy;
    logic             exp_ov;
    int               exp_src;
    logic             exp_err;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [WIDTH-1:0] word(int ch, int salt);
    return 32'h1234_5675 + WIDTH'(ch) + WIDTH'(salt) * 32'h100;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int salt);
    for (int i = 0; i < N; i++) in_data_i[i*WIDTH +: WIDTH] = word(i, salt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model state
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_src;
  int               m_ptr;

  initial begin
    mode_i = 1'b0; order_i = '0; in_valid_i = '0; out_ready_i = 1'b1;
    in_data_i = '0;
    rst_n = 1'b0;
    #2;
    chk("reset_out_valid", 64'(out_valid_o), 64'd0);
    chk("reset_out_data",  64'(out_data_o),  64'd0);
    chk("reset_out_src",   64'(out_src_o),   64'd0);
    chk("reset_sel_err",   64'(sel_err_o),   64'd0);
    do_reset();

    // ---- Direct-mode vector table (out_ready held high) ----
    tbl[0] = '{1'b0, 3'd3, 5'b01000, 5'b01000, 1'b1, 3, 1'b0};
    tbl[1] = '{1'b0, 3'd6, 5'b11111, 5'b00000, 1'b0, 3, 1'b1};
    tbl[2] = '{1'b0, 3'd1, 5'b00100, 5'b00000, 1'b0, 3, 1'b0};
    tbl[3] = '{1'b0, 3'd0, 5'b11111, 5'b00001, 1'b1, 0, 1'b0};
    tbl[4] = '{1'b0, 3'd5, 5'b00000, 5'b00000, 1'b0, 0, 1'b1};
    tbl[5] = '{1'b0, 3'd4, 5'b10000, 5'b10000, 1'b1, 4, 1'b0};
    tbl[6] = '{1'b0, 3'd7, 5'b11111, 5'b00000, 1'b0, 4, 1'b1};
    set_data(0);
    out_ready_i = 1'b1;
    for (int v = 0; v < 7; v++) begin
      mode_i = tbl[v].mode; order_i = tbl[v].order; in_valid_i = tbl[v].vld;
      #2;
      chk($sformatf("tbl%0d_in_ready", v), 64'(in_ready_o), 64'(tbl[v].exp_rdy));
      tick();
      chk($sformatf("tbl%0d_out_valid", v), 64'(out_valid_o), 64'(tbl[v].exp_ov));
      chk($sformatf("tbl%0d_out_src", v),   64'(out_src_o),   64'(tbl[v].exp_src));
      chk($sformatf("tbl%0d_sel_err", v),   64'(sel_err_o),   64'(tbl[v].exp_err));
      chk($sformatf("tbl%0d_out_data", v),  64'(out_data_o),  64'(word(tbl[v].exp_src, 0)));
    end
    // sel_err not raised when slot busy
    mode_i = 1'b0; order_i = 3'd2; in_valid_i = 5'b00100; tick();
    out_ready_i = 1'b0; order_i = 3'd6; tick();
    chk("selerr_busy", 64'(sel_err_o), 64'd0);
    out_ready_i = 1'b1;

    // ---- RR fairness ----
    do_reset();
    mode_i = 1'b1; in_valid_i = '1; out_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      set_data(c);
      #2;
      chk($sformatf("fair%0d_in_ready", c), 64'(in_ready_o), 64'(1 << (c % N)));
      tick();
      chk($sformatf("fair%0d_src", c),  64'(out_src_o),  64'(c % N));
      chk($sformatf("fair%0d_data", c), 64'(out_data_o), 64'(word(c % N, c)));
      chk($sformatf("fair%0d_ov", c),   64'(out_valid_o), 64'd1);
    end

    // ---- RR skip and wrap: grant 3 leaves ptr=4 ----
    in_valid_i = 5'b01000; tick();
    chk("wrap_g3", 64'(out_src_o), 64'd3);
    in_valid_i = 5'b00011; #2;
    chk("wrap_rdy0", 64'(in_ready_o), 64'b00001);
    tick();
    chk("wrap_g0", 64'(out_src_o), 64'd0);
    #2;
    chk("wrap_rdy1", 64'(in_ready_o), 64'b00010);
    tick();
    chk("wrap_g1", 64'(out_src_o), 64'd1);
    in_valid_i = '1; tick();
    chk("wrap_ptr2", 64'(out_src_o), 64'd2);

    // ---- Backpressure: word from ch2 (salt 9) held, ptr=3 ----
    out_ready_i = 1'b0; set_data(50);
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("bp%0d_in_ready", c), 64'(in_ready_o), 64'd0);
      tick();
      chk($sformatf("bp%0d_data", c), 64'(out_data_o), 64'(word(2, 9)));
      chk($sformatf("bp%0d_src", c),  64'(out_src_o),  64'd2);
      chk($sformatf("bp%0d_ov", c),   64'(out_valid_o), 64'd1);
    end
    out_ready_i = 1'b1; #2;
    chk("bp_release_rdy", 64'(in_ready_o), 64'b01000);
    tick();
    chk("bp_release_ov",   64'(out_valid_o), 64'd1);
    chk("bp_release_data", 64'(out_data_o),  64'(word(3, 50)));

    // ---- Mode switch: ptr preserved across direct-mode grants ----
    do_reset();
    mode_i = 1'b1; in_valid_i = '1; out_ready_i = 1'b1; set_data(0);
    tick(); chk("ms_rr0", 64'(out_src_o), 64'd0);
    tick(); chk("ms_rr1", 64'(out_src_o), 64'd1);
    mode_i = 1'b0; order_i = 3'd0;
    tick(); chk("ms_dir0", 64'(out_src_o), 64'd0);
    mode_i = 1'b1;
    tick(); chk("ms_rr2", 64'(out_src_o), 64'd2);

    // ---- Reset mid-stream ----
    mode_i = 1'b0; order_i = 3'd1; in_valid_i = 5'b00010;
    in_data_i[1*WIDTH +: WIDTH] = 32'hDEADBEEF;
    tick();
    chk("mid_loaded", 64'(out_data_o), 64'hDEADBEEF);
    out_ready_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov",   64'(out_valid_o), 64'd0);
    chk("mid_rst_data", 64'(out_data_o),  64'd0);
    chk("mid_rst_src",  64'(out_src_o),   64'd0);
    tick(); tick();
    rst_n = 1'b1;
    mode_i = 1'b1; in_valid_i = '1; out_ready_i = 1'b1; set_data(0);
    #2;
    chk("mid_release_rdy", 64'(in_ready_o), 64'b00001);
    tick();
    chk("mid_release_src", 64'(out_src_o), 64'd0);

    // ---- Randomized run against reference model ----
    do_reset();
    m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
    for (int c = 0; c < 400; c++) begin
      int g;
      int ord;
      logic slot;
      logic [N-1:0] exp_rdy;
      logic exp_err;
      mode_i      = 1'($urandom_range(0, 1));
      ord         = $urandom_range(0, (1 << SEL_W) - 1);
      order_i     = SEL_W'(ord);
      in_valid_i  = N'($urandom) & N'($urandom | $urandom);
      out_ready_i = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) in_data_i[i*WIDTH +: WIDTH] = $urandom;

      slot = !m_valid || out_ready_i;
      g = -1;
      if (!mode_i) begin
        if (ord < N && in_valid_i[ord]) g = ord;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && in_valid_i[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      exp_rdy = '0;
      if (g >= 0 && slot) exp_rdy[g] = 1'b1;
      exp_err = !mode_i && ord >= N && slot;
      #2;
      chk($sformatf("rnd%0d_in_ready", c), 64'(in_ready_o), 64'(exp_rdy));
      if (g >= 0 && slot) begin
        m_valid = 1'b1;
        m_data  = in_data_i[g*WIDTH +: WIDTH];
        m_src   = g;
        if (mode_i) m_ptr = (g + 1) % N;
      end else if (out_ready_i) begin
        m_valid = 1'b0;
      end
      tick();
      chk($sformatf("rnd%0d_ov", c),   64'(out_valid_o), 64'(m_valid));
      chk($sformatf("rnd%0d_data", c), 64'(out_data_o),  64'(m_data));
      chk($sformatf("rnd%0d_src", c),  64'(out_src_o),   64'(m_src));
      chk($sformatf("rnd%0d_err", c),  64'(sel_err_o),   64'(exp_err));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
